// File: rtl/reg_file_wb_pkg.sv
// Shared constants and register-index type for the integer register file,
// decode and write-back stages.
package reg_file_wb_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [AW-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = {AW{1'b0}};

    // True when the write-back port targets a real (non-zero) read index this cycle
    function automatic logic wb_hits(input logic we, input reg_idx_t wa, input reg_idx_t ra);
        return we & (wa == ra) & (ra != ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_file_wb_scoreboard.sv
// Per-register pending scoreboard: issue marks a destination busy, write-back
// clears it, and used sources that are busy and not being bypassed stall decode.
module reg_file_wb_scoreboard
    import reg_file_wb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  reg_idx_t         i_rs1_addr,
    input  reg_idx_t         i_rs2_addr,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    input  logic             i_issue_valid,
    input  reg_idx_t         i_issue_rd,
    input  logic             i_reg_write,
    input  reg_idx_t         i_rd_addr,
    output logic             o_operand_stall,
    output logic [NREGS-1:0] o_busy_vec
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic             w_stall;

    // Hazard term; bit 0 is never busy so x0 cannot stall
    always_comb begin
        w_stall = (i_rs1_used & r_busy[i_rs1_addr] & ~wb_hits(i_reg_write, i_rd_addr, i_rs1_addr))
                | (i_rs2_used & r_busy[i_rs2_addr] & ~wb_hits(i_reg_write, i_rd_addr, i_rs2_addr));
    end

    // Decode set/clear strobes per index, skipping x0
    always_comb begin
        w_set = {NREGS{1'b0}};
        w_clr = {NREGS{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            w_set[i] = i_issue_valid & ~w_stall & (i_issue_rd == reg_idx_t'(i));
            w_clr[i] = i_reg_write & (i_rd_addr == reg_idx_t'(i));
        end
    end

    // Busy bits: set is applied after clear so a re-issuing producer stays pending
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= {NREGS{1'b0}};
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign o_operand_stall = w_stall;
    assign o_busy_vec      = r_busy;

endmodule

// File: rtl/reg_file_wb.sv
// Integer register file terminating write-back: two bypassed combinational
// read ports for decode plus the pending scoreboard that drives operand_stall.
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  reg_idx_t         i_rs1_addr,
    input  reg_idx_t         i_rs2_addr,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    input  logic             i_issue_valid,
    input  reg_idx_t         i_issue_rd,
    input  logic             i_reg_write,
    input  reg_idx_t         i_rd_addr,
    input  logic [XLEN-1:0]  i_write_back_data,
    output logic             o_operand_stall,
    output logic [NREGS-1:0] o_busy_vec
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_byp1;
    logic            w_byp2;

    // Register array; x0 is never written and stays at its reset value of zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (i_reg_write && (i_rd_addr != ZERO_REG)) begin
            r_regs[i_rd_addr] <= i_write_back_data;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Bypass is gated by reset so held-in-reset reads return zero
    always_comb begin
        w_byp1 = i_rst_n & wb_hits(i_reg_write, i_rd_addr, i_rs1_addr);
        w_byp2 = i_rst_n & wb_hits(i_reg_write, i_rd_addr, i_rs2_addr);
    end

    // Read muxes: x0, then write-back bypass, then array
    always_comb begin
        if (i_rs1_addr == ZERO_REG) begin
            w_rs1_data = {XLEN{1'b0}};
        end else if (w_byp1) begin
            w_rs1_data = i_write_back_data;
        end else begin
            w_rs1_data = r_regs[i_rs1_addr];
        end
        if (i_rs2_addr == ZERO_REG) begin
            w_rs2_data = {XLEN{1'b0}};
        end else if (w_byp2) begin
            w_rs2_data = i_write_back_data;
        end else begin
            w_rs2_data = r_regs[i_rs2_addr];
        end
    end

    assign o_rs1_data = w_rs1_data;
    assign o_rs2_data = w_rs2_data;

    reg_file_wb_scoreboard u_scoreboard (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rs1_addr     (i_rs1_addr),
        .i_rs2_addr     (i_rs2_addr),
        .i_rs1_used     (i_rs1_used),
        .i_rs2_used     (i_rs2_used),
        .i_issue_valid  (i_issue_valid),
        .i_issue_rd     (i_issue_rd),
        .i_reg_write    (i_reg_write),
        .i_rd_addr      (i_rd_addr),
        .o_operand_stall(o_operand_stall),
        .o_busy_vec     (o_busy_vec)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: reset, write/read, x0,
// bypass, scoreboard stall/release, set-vs-clear race and stalled issue.
module tb_reg_file_wb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [63:0] wb_data;
    logic        operand_stall;
    logic [31:0] busy_vec;

    int n_err;
    int n_chk;

    reg_file_wb dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rs1_addr       (rs1_addr),
        .i_rs2_addr       (rs2_addr),
        .i_rs1_used       (rs1_used),
        .i_rs2_used       (rs2_used),
        .o_rs1_data       (rs1_data),
        .o_rs2_data       (rs2_data),
        .i_issue_valid    (issue_valid),
        .i_issue_rd       (issue_rd),
        .i_reg_write      (reg_write),
        .i_rd_addr        (rd_addr),
        .i_write_back_data(wb_data),
        .o_operand_stall  (operand_stall),
        .o_busy_vec       (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        reg_write   = 1'b0;
        rd_addr     = 5'd0;
        wb_data     = 64'd0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        idle();
        #1;
        chk("por_busy", {32'd0, busy_vec}, 64'd0);
        chk("por_stall", {63'd0, operand_stall}, 64'd0);
        chk("por_rs1", rs1_data, 64'd0);
        #1;
        rst_n = 1'b1;
        tick();

        // Write x7, read back on rs2
        reg_write = 1'b1; rd_addr = 5'd7; wb_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        idle();
        rs2_addr = 5'd7;
        #1;
        chk("wr_rd_x7", rs2_data, 64'hDEADBEEF_CAFEF00D);

        // Write to x0 is dropped, no bypass either
        reg_write = 1'b1; rd_addr = 5'd0; wb_data = 64'h55; rs1_addr = 5'd0;
        #1;
        chk("x0_bypass", rs1_data, 64'd0);
        tick();
        idle();
        #1;
        chk("x0_after", rs1_data, 64'd0);

        // Same-cycle bypass on x3
        reg_write = 1'b1; rd_addr = 5'd3; wb_data = 64'h10;
        tick();
        idle();
        rs1_addr = 5'd3;
        #1;
        chk("x3_old", rs1_data, 64'h10);
        reg_write = 1'b1; rd_addr = 5'd3; wb_data = 64'h20;
        #1;
        chk("x3_bypass", rs1_data, 64'h20);
        tick();
        idle();
        rs1_addr = 5'd3;
        #1;
        chk("x3_stored", rs1_data, 64'h20);

        // Scoreboard stall and release on x9
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        idle();
        #1;
        chk("busy_x9", {32'd0, busy_vec}, 64'h0000_0200);
        rs1_addr = 5'd9; rs1_used = 1'b1;
        #1;
        chk("stall_x9", {63'd0, operand_stall}, 64'd1);
        rs1_used = 1'b0;
        #1;
        chk("nostall_unused", {63'd0, operand_stall}, 64'd0);
        rs1_used = 1'b1; reg_write = 1'b1; rd_addr = 5'd9; wb_data = 64'h77;
        #1;
        chk("wb_release_stall", {63'd0, operand_stall}, 64'd0);
        chk("wb_release_data", rs1_data, 64'h77);
        tick();
        idle();
        #1;
        chk("busy_clr_x9", {32'd0, busy_vec}, 64'd0);

        // Set-vs-clear race on x4: set wins, data still written
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        idle();
        reg_write = 1'b1; rd_addr = 5'd4; wb_data = 64'hAA;
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        idle();
        rs1_addr = 5'd4;
        #1;
        chk("race_busy", {32'd0, busy_vec}, 64'h0000_0010);
        chk("race_data", rs1_data, 64'hAA);

        // Stalled issue is ignored
        issue_valid = 1'b1; issue_rd = 5'd2;
        tick();
        idle();
        rs2_addr = 5'd2; rs2_used = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6;
        #1;
        chk("stall_rs2", {63'd0, operand_stall}, 64'd1);
        tick();
        idle();
        #1;
        chk("stalled_issue", {32'd0, busy_vec}, 64'h0000_0014);

        // Set and clear on different indices, and issue to x0
        reg_write = 1'b1; rd_addr = 5'd2; wb_data = 64'h99;
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        rs2_addr = 5'd2;
        #1;
        chk("set_clr_diff", {32'd0, busy_vec}, 64'h0000_0050);
        chk("x2_data", rs2_data, 64'h99);

        // Mid-run asynchronous reset with an in-flight write
        reg_write = 1'b1; rd_addr = 5'd5; wb_data = 64'h1234;
        tick();
        idle();
        rs1_addr = 5'd5;
        #1;
        chk("x5_pre_rst", rs1_data, 64'h1234);
        rs2_addr = 5'd4; rs2_used = 1'b1;
        reg_write = 1'b1; rd_addr = 5'd5; wb_data = 64'hFFFF;
        issue_valid = 1'b1; issue_rd = 5'd8;
        rst_n = 1'b0;
        #1;
        chk("rst_rs1", rs1_data, 64'd0);
        chk("rst_busy", {32'd0, busy_vec}, 64'd0);
        chk("rst_stall", {63'd0, operand_stall}, 64'd0);
        tick();
        rst_n = 1'b1;
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd7;
        #1;
        chk("post_rst_x5", rs1_data, 64'd0);
        chk("post_rst_x7", rs2_data, 64'd0);
        chk("post_rst_busy", {32'd0, busy_vec}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
